vga_timing_pattern_gen: RTL and testbench
=========================================

Name: vga_timing_pattern_gen

Overview:
Parametrised successor to the fixed 640x480 sync generator and test-pattern logic. It generates horizontal and vertical timing from parameters and supports configurable sync polarity and a pixel-clock enable, so it can run from a faster system clock. It also provides line and frame strobes, a frame counter, and four runtime-selectable test patterns. It sits between the PLL pixel clock domain and the VGA pins, and later will be replaced by or muxed with a framebuffer reader.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
POS_W, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  pixel/system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  pixel advance qualifier; tie 1 for one pixel per clk
mode  input  2  pattern select, sampled at frame start only
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
display_on  output  1  high while presenting a visible pixel
hpos  output  POS_W  presented pixel column
vpos  output  POS_W  presented line
line_start  output  1  one-clk strobe when hpos==0 is presented
frame_start  output  1  one-clk strobe when (0,0) is presented
frame_count  output  8  frames completed since reset, wraps 255->0
rgb  output  3  {b,g,r} pattern pixel, 0 when display_on=0

Behaviour:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL is the analogous vertical sum.
- Internal counters (hc, vc) reset to (0,0).
  - On each clk edge with enable=1, hc increments.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with that wrap, vc wraps to 0 and the frame counter increments (mod 256).
  - With enable=0, all counters and registered outputs hold.
- All outputs are registered. On an enabled edge they take the values derived from the pre-increment (hc, vc), so outputs describe position (hpos, vpos) one enabled cycle behind the counters. hsync, vsync, display_on, rgb and hpos/vpos are therefore mutually cycle-aligned.
- Output derivation:
  - display_on = hc<H_DISPLAY && vc<V_DISPLAY.
  - hsync is at active level iff H_DISPLAY+H_FRONT <= hc < H_DISPLAY+H_FRONT+H_SYNC; otherwise it is at the inactive level.
  - vsync is at active level iff V_DISPLAY+V_FRONT <= vc < V_DISPLAY+V_FRONT+V_SYNC.
- Strobes:
  - line_start=1 for exactly one clk after an enabled edge presenting hc==0.
  - frame_start additionally requires vc==0.
  - Both strobes clear on the next clk edge regardless of enable.
- Mode latching: when (0,0) is presented, mode_q<=mode and that frame uses mode_q. A mode change mid-frame has no effect until the next frame_start.
- frame_count output is the count presented with the pixel. It updates at the same edge as frame_start, i.e. it reads N during frame N (first frame = 0).
- Patterns (x=hpos, y=vpos, all forced to 0 when display_on=0):
  - mode 0, grid: r=(x[2:0]==0)|(y[2:0]==0); g=y[4]; b=x[4].
  - mode 1, bars: {b,g,r}=x[8:6].
  - mode 2, scrolling checker: v=(x+frame_count)[5] ^ y[5]; rgb={v,v,v}. The sum is truncated to POS_W.
  - mode 3: solid white 3'b111.
- Reset (async assert, sync-to-clk release is the integrator's job):
  - hc=vc=0, frame_count=0, mode_q=0.
  - hpos=vpos=0, display_on=0, rgb=0, line_start=frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- The first enabled edge after reset presents (0,0) with display_on=1, line_start=frame_start=1 and frame_count=0.
- Reset mid-line or mid-frame: outputs return to the idle values immediately (asynchronously), then restart from (0,0).

Test Plan:
- Reset/idle: assert reset_n=0 mid-frame -> hsync=vsync=1 (POL=0), rgb=0, display_on=0, strobes 0 within the same cycle. After release, the first edge shows hpos=vpos=0, frame_start=1, frame_count=0.
- Line timing (defaults, enable=1): hsync low for exactly 96 clks beginning at hpos=656; line_start period exactly 800 clks; display_on high for 640 clks per visible line.
- Frame timing (small params H=8/1/2/1, V=4/1/1/1): vsync active only while vpos==5; frame_start every 12*7=84 clks; frame_count 0->1->2 across frame_starts; wraps 255->0 after 256 frames.
- Enable gating: enable toggled 1,0,1,0 -> hpos advances once per two clks, line_start period doubles to 1600 clks, each strobe still lasts one clk.
- Mode latch: switch mode 0->1 at vpos=100 -> rgb stays grid pattern until the next frame_start. Then at (x=130, y=20) rgb=3'b010 (bars).
- Pattern values, frame_count=0: mode 0 at (8,3) -> rgb={0,0,1}; mode 0 at (16,16) -> {1,1,1}; mode 2 at (32,0) -> 3'b111, (32,32) -> 3'b000; mode 3 in blanking (hpos=700) -> 0.

Source files
------------

// File: rtl/vga_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pattern_gen
// Brief    : Parametrised VGA sync generator with pixel-clock enable, line and
//            frame strobes, a frame counter and four runtime test patterns.
//            All outputs are registered and describe the pixel at the
//            pre-increment counter position. Patterns index hpos up to bit 8,
//            so POS_W must be at least 9.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_pattern_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int POS_W     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count,
    output logic [2:0]       rgb
);

    localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_W-1:0] c_h_last     = POS_W'(c_h_total - 1);
    localparam logic [POS_W-1:0] c_v_last     = POS_W'(c_v_total - 1);
    localparam logic [POS_W-1:0] c_h_disp     = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] c_v_disp     = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] c_hs_start   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] c_hs_end     = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] c_vs_start   = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0] c_vs_end     = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [POS_W-1:0] r_hc;
    logic [POS_W-1:0] r_vc;
    logic [7:0]       r_fc;
    logic [1:0]       r_mode_q;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_origin;
    logic       w_de;
    logic       w_hs_act;
    logic       w_vs_act;
    logic [1:0] w_mode;
    logic       w_chk;
    logic [2:0] w_pat;
    logic [2:0] w_rgb;

    assign w_h_last = (r_hc == c_h_last);
    assign w_v_last = (r_vc == c_v_last);
    assign w_origin = (r_hc == '0) && (r_vc == '0);
    assign w_de     = (r_hc < c_h_disp) && (r_vc < c_v_disp);
    assign w_hs_act = (r_hc >= c_hs_start) && (r_hc < c_hs_end);
    assign w_vs_act = (r_vc >= c_vs_start) && (r_vc < c_vs_end);

    // The origin pixel already belongs to the new frame, so it uses the mode
    // being latched on this very edge rather than the previous frame's mode.
    assign w_mode = w_origin ? mode : r_mode_q;

    // Scrolling checker: bit 5 of (x + frame_count) truncated to POS_W.
    assign w_chk = 1'((r_hc + POS_W'(r_fc)) >> 5) ^ r_vc[5];

    // Pattern lookup for the pixel about to be presented.
    always_comb begin
        w_pat = 3'b000;
        case (w_mode)
            2'd0:    w_pat = {r_hc[4], r_vc[4], (r_hc[2:0] == 3'd0) || (r_vc[2:0] == 3'd0)};
            2'd1:    w_pat = r_hc[8:6];
            2'd2:    w_pat = {w_chk, w_chk, w_chk};
            default: w_pat = 3'b111;
        endcase
    end

    assign w_rgb = w_de ? w_pat : 3'b000;

    // Raster counters, frame counter and per-frame mode latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc     <= '0;
            r_vc     <= '0;
            r_fc     <= 8'd0;
            r_mode_q <= 2'd0;
        end else if (enable) begin
            if (w_origin) begin
                r_mode_q <= mode;
            end
            if (w_h_last) begin
                r_hc <= '0;
                if (w_v_last) begin
                    r_vc <= '0;
                    r_fc <= r_fc + 8'd1;
                end else begin
                    r_vc <= r_vc + POS_W'(1);
                end
            end else begin
                r_hc <= r_hc + POS_W'(1);
            end
        end
    end

    // Registered pixel outputs; strobes self-clear every clk, the rest hold
    // while enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_on  <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            rgb         <= 3'b000;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) begin
                hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
                display_on  <= w_de;
                hpos        <= r_hc;
                vpos        <= r_vc;
                line_start  <= (r_hc == '0);
                frame_start <= w_origin;
                frame_count <= r_fc;
                rgb         <= w_rgb;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_pattern_gen
// Brief    : Scoreboard bench for vga_timing_pattern_gen. Three instances
//            (default 640x480, tiny 8x4, medium 160x48) run side by side
//            against a behavioural raster model; extra monitors measure
//            line/frame timing and capture selected pattern pixels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_pattern_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic [2:0] rgb;
    } out_t;

    // index 0 = default timing, 1 = tiny, 2 = medium
    int HD [3] = '{640, 8, 160};
    int HF [3] = '{16, 1, 4};
    int HS [3] = '{96, 2, 8};
    int HB [3] = '{48, 1, 4};
    int VD [3] = '{480, 4, 48};
    int VF [3] = '{10, 1, 1};
    int VS [3] = '{2, 1, 1};
    int VB [3] = '{33, 1, 2};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode_a  [3];
    logic       hs_o    [3];
    logic       vs_o    [3];
    logic       de_o    [3];
    logic [9:0] hpos_o  [3];
    logic [9:0] vpos_o  [3];
    logic       ls_o    [3];
    logic       fs_o    [3];
    logic [7:0] fc_o    [3];
    logic [2:0] rgb_o   [3];

    int total = 0;
    int bad   = 0;

    // model state
    int   mhc [3];
    int   mvc [3];
    int   mfc [3];
    int   mmq [3];
    out_t mo  [3];
    out_t sbq [$];

    always #5 clk = ~clk;

    vga_timing_pattern_gen u_def (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode_a[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .display_on(de_o[0]),
        .hpos(hpos_o[0]), .vpos(vpos_o[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .frame_count(fc_o[0]), .rgb(rgb_o[0])
    );

    vga_timing_pattern_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_sml (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode_a[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .display_on(de_o[1]),
        .hpos(hpos_o[1]), .vpos(vpos_o[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .frame_count(fc_o[1]), .rgb(rgb_o[1])
    );

    vga_timing_pattern_gen #(
        .H_DISPLAY(160), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
    ) u_med (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode_a[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .display_on(de_o[2]),
        .hpos(hpos_o[2]), .vpos(vpos_o[2]), .line_start(ls_o[2]),
        .frame_start(fs_o[2]), .frame_count(fc_o[2]), .rgb(rgb_o[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pixel for instance i at raster (x,y), frame f, pattern md.
    function automatic out_t pix(int i, int x, int y, int f, int md);
        out_t o;
        logic r, g, b, v;
        int   tx;
        o    = '0;
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.fc = 8'(f);
        o.de = (x < HD[i]) && (y < VD[i]);
        o.hs = !((x >= HD[i] + HF[i]) && (x < HD[i] + HF[i] + HS[i]));
        o.vs = !((y >= VD[i] + VF[i]) && (y < VD[i] + VF[i] + VS[i]));
        case (md)
            0: begin
                r = (x % 8 == 0) || (y % 8 == 0);
                g = ((y / 16) % 2) == 1;
                b = ((x / 16) % 2) == 1;
                o.rgb = {b, g, r};
            end
            1: o.rgb = 3'((x / 64) % 8);
            2: begin
                tx = (x + f) % 1024;
                v = (((tx / 32) % 2) ^ ((y / 32) % 2)) == 1;
                o.rgb = {v, v, v};
            end
            default: o.rgb = 3'b111;
        endcase
        if (!o.de) o.rgb = 3'b000;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mhc[i] = 0; mvc[i] = 0; mfc[i] = 0; mmq[i] = 0;
            mo[i] = '0; mo[i].hs = 1'b1; mo[i].vs = 1'b1;
        end
    endtask

    task automatic model_edge(input int i, input logic en);
        if (en) begin
            if (mhc[i] == 0 && mvc[i] == 0) mmq[i] = int'(mode_a[i]);
            mo[i] = pix(i, mhc[i], mvc[i], mfc[i], mmq[i]);
            mo[i].ls = (mhc[i] == 0);
            mo[i].fs = (mhc[i] == 0) && (mvc[i] == 0);
            mhc[i]++;
            if (mhc[i] == HD[i] + HF[i] + HS[i] + HB[i]) begin
                mhc[i] = 0;
                mvc[i]++;
                if (mvc[i] == VD[i] + VF[i] + VS[i] + VB[i]) begin
                    mvc[i] = 0;
                    mfc[i] = (mfc[i] + 1) % 256;
                end
            end
        end else begin
            mo[i].ls = 1'b0;
            mo[i].fs = 1'b0;
        end
    endtask

    task automatic compare_all();
        out_t act, exp;
        for (int i = 0; i < 3; i++) begin
            act = {hs_o[i], vs_o[i], de_o[i], hpos_o[i], vpos_o[i],
                   ls_o[i], fs_o[i], fc_o[i], rgb_o[i]};
            if (sbq.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp = sbq.pop_front();
                check($sformatf("dut%0d_px", i), 64'(act), 64'(exp));
            end
        end
    endtask

    task automatic step(input logic en);
        enable = en;
        for (int i = 0; i < 3; i++) begin
            model_edge(i, en);
            sbq.push_back(mo[i]);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic rst_cycle();
        for (int i = 0; i < 3; i++) sbq.push_back(mo[i]);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Step until the medium model is about to present line v of frame f.
    task automatic run_to(input int f, input int v);
        int n = 0;
        while (!(mfc[2] == f && mvc[2] == v && mhc[2] == 0) && n < 40000) begin
            step(1'b1);
            n++;
        end
        if (n >= 40000) check("run_to_timeout", 64'd1, 64'd0);
    endtask

    // ---- timing monitors and pattern captures ----
    int cyc = 0;
    int ls_last = -1, ls_per = 0, ls_run = 0, ls_maxrun = 0;
    int hs_run = 0, hs_len = 0, hs_start = -1;
    int de_run = 0, de_len = 0;
    int fs_last = -1, fs_per = 0, fc_prev = -1, fc_bad = 0, wrap_seen = 0;
    int vs_seen = 0, vs_bad = 0;
    logic [3:0] cap [8];

    always @(negedge clk) begin
        cyc++;
        if (ls_o[0]) begin
            if (ls_last >= 0) ls_per = cyc - ls_last;
            ls_last = cyc;
            ls_run++;
            if (ls_run > ls_maxrun) ls_maxrun = ls_run;
        end else begin
            ls_run = 0;
        end
        if (!hs_o[0]) begin
            if (hs_run == 0) hs_start = int'(hpos_o[0]);
            hs_run++;
        end else begin
            if (hs_run > 0) hs_len = hs_run;
            hs_run = 0;
        end
        if (de_o[0]) de_run++;
        else begin
            if (de_run > 0) de_len = de_run;
            de_run = 0;
        end
        if (fs_o[1]) begin
            if (fs_last >= 0) fs_per = cyc - fs_last;
            fs_last = cyc;
            if (fc_prev >= 0) begin
                if (int'(fc_o[1]) != (fc_prev + 1) % 256) fc_bad++;
                if (fc_prev == 255 && fc_o[1] == 8'd0) wrap_seen = 1;
            end
            fc_prev = int'(fc_o[1]);
        end
        if (reset_n && !vs_o[1]) begin
            vs_seen++;
            if (vpos_o[1] != 10'd5) vs_bad++;
        end
        if (fc_o[2] == 8'd0 && hpos_o[2] == 10'd8   && vpos_o[2] == 10'd3)  cap[0] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd0 && hpos_o[2] == 10'd16  && vpos_o[2] == 10'd16) cap[1] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd0 && hpos_o[2] == 10'd8   && vpos_o[2] == 10'd44) cap[2] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd1 && hpos_o[2] == 10'd130 && vpos_o[2] == 10'd20) cap[3] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd2 && hpos_o[2] == 10'd30  && vpos_o[2] == 10'd0)  cap[4] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd2 && hpos_o[2] == 10'd32  && vpos_o[2] == 10'd32) cap[5] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd3 && hpos_o[2] == 10'd170 && vpos_o[2] == 10'd5)  cap[6] = {de_o[2], rgb_o[2]};
        if (fc_o[2] == 8'd3 && hpos_o[2] == 10'd5   && vpos_o[2] == 10'd5)  cap[7] = {de_o[2], rgb_o[2]};
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cap_exp [8];
        cap_exp = '{4'b1001, 4'b1111, 4'b1001, 4'b1010, 4'b1111, 4'b1000, 4'b0000, 4'b1111};
        for (int i = 0; i < 8; i++) cap[i] = 4'bxxxx;
        for (int i = 0; i < 3; i++) mode_a[i] = 2'd0;
        model_reset();

        // reset state
        @(negedge clk);
        check("rst_idle", {hs_o[0], vs_o[0], de_o[0], ls_o[0], fs_o[0], rgb_o[0]}, 8'b11000000);
        check("rst_pos", {hpos_o[0], vpos_o[0], fc_o[0]}, 28'd0);
        rst_cycle();
        rst_cycle();

        // first enabled edge after release presents the origin
        reset_n = 1'b1;
        step(1'b1);
        check("first_fs_ls_de", {fs_o[0], ls_o[0], de_o[0]}, 3'b111);
        check("first_pos_fc", {hpos_o[0], vpos_o[0], fc_o[0]}, 28'd0);

        // grid frame 0, switch to bars mid-frame
        run_to(0, 40);
        mode_a[2] = 2'd1;
        check("line_period", 64'(ls_per), 64'd800);
        check("hsync_len", 64'(hs_len), 64'd96);
        check("hsync_start", 64'(hs_start), 64'd656);
        check("de_len", 64'(de_len), 64'd640);
        check("small_frame_period", 64'(fs_per), 64'd84);

        run_to(1, 30);
        mode_a[2] = 2'd2;
        run_to(2, 40);
        mode_a[2] = 2'd3;
        run_to(3, 6);

        check("small_vsync_only_v5", 64'(vs_bad), 64'd0);
        check("small_vsync_seen", 64'(vs_seen > 0), 64'd1);
        check("small_fc_seq", 64'(fc_bad), 64'd0);
        check("small_fc_wrap", 64'(wrap_seen), 64'd1);
        for (int i = 0; i < 8; i++) check($sformatf("pattern_cap%0d", i), 64'(cap[i]), 64'(cap_exp[i]));

        // asynchronous reset in the middle of a frame
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_def", {hs_o[0], vs_o[0], de_o[0], ls_o[0], fs_o[0], rgb_o[0]}, 8'b11000000);
        check("async_rst_med", {hs_o[2], vs_o[2], de_o[2], rgb_o[2], hpos_o[2]}, 16'hC000);
        model_reset();
        rst_cycle();
        rst_cycle();
        reset_n = 1'b1;
        step(1'b1);
        check("restart_fs_pos", {fs_o[0], hpos_o[0], vpos_o[0], fc_o[0]}, {1'b1, 28'd0});

        // enable gating at half rate
        ls_last = -1;
        ls_maxrun = 0;
        for (int i = 0; i < 4000; i++) step((i % 2) == 1);
        check("gated_line_period", 64'(ls_per), 64'd1600);
        check("gated_strobe_width", 64'(ls_maxrun), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
